// File: rtl/saxpy_row_serializer.sv
// Buffers 512-bit saxpy result vectors in a small FIFO and streams each one out
// as ROWS row beats over valid/ready; drops from the unstallable producer are flagged.
module saxpy_row_serializer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                            ref_clk,
    input  logic                            rst,
    input  logic [WORD_W*LANES*ROWS-1:0]    vec_in,
    input  logic                            vec_valid,
    output logic [WORD_W*LANES-1:0]         row_out,
    output logic                            row_valid,
    input  logic                            row_ready,
    output logic                            row_last,
    output logic [$clog2(ROWS)-1:0]         row_idx,
    output logic [$clog2(DEPTH+1)-1:0]      level,
    output logic                            overflow
);

    localparam int unsigned ROW_W = WORD_W * LANES;
    localparam int unsigned IDX_W = $clog2(ROWS);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [ROW_W-1:0] mem      [DEPTH][ROWS];
    logic [ROW_W-1:0] vec_rows [ROWS];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] rptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic             beat;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic             bypass;

    // Split the incoming vector into row slices.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            vec_rows[r] = vec_in[r*ROW_W +: ROW_W];
        end
    end

    // Next-state for pointers, row index and occupancy.
    always_comb begin
        beat      = row_valid && row_ready;
        pop       = beat && (row_idx == IDX_W'(ROWS - 1));
        full      = (level == LVL_W'(DEPTH));
        push      = vec_valid && (!full || pop);
        drop      = vec_valid && full && !pop;
        idx_nxt   = row_idx;
        rptr_nxt  = rptr;
        level_nxt = level;
        if (beat) begin
            if (pop) begin
                idx_nxt  = '0;
                rptr_nxt = rptr + PTR_W'(1);
            end else begin
                idx_nxt  = row_idx + IDX_W'(1);
            end
        end
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
        // A vector written into the slot that becomes head must be forwarded, since storage updates this same edge.
        bypass  = push && (wptr == rptr_nxt);
        row_nxt = bypass ? vec_rows[idx_nxt] : mem[rptr_nxt][idx_nxt];
    end

    // Vector storage; not reset, contents only qualified by level.
    always_ff @(posedge ref_clk) begin
        if (!rst && push) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[wptr][r] <= vec_rows[r];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            row_idx   <= '0;
            overflow  <= 1'b0;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            row_out   <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr      <= rptr_nxt;
            row_idx   <= idx_nxt;
            level     <= level_nxt;
            row_valid <= (level_nxt != '0);
            row_last  <= (level_nxt != '0) && (idx_nxt == IDX_W'(ROWS - 1));
            if (drop) begin
                overflow <= 1'b1;
            end
            if (level_nxt != '0) begin
                row_out <= row_nxt;
            end
        end
    end

endmodule

// File: tb/tb_saxpy_row_serializer.sv
// Self-checking bench for saxpy_row_serializer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_saxpy_row_serializer;

    logic         ref_clk;
    logic         rst;
    logic [511:0] vec_in;
    logic         vec_valid;
    logic [127:0] row_out;
    logic         row_valid;
    logic         row_ready;
    logic         row_last;
    logic [1:0]   row_idx;
    logic [1:0]   level;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;

    // Reference model: a queue of whole vectors plus the row position in the head.
    logic [511:0] mq[$];
    int           m_idx = 0;
    bit           m_ovf = 0;

    typedef struct {
        logic         vv;
        logic         rdy;
        logic         ev;
        logic [1:0]   eidx;
        logic         elast;
        logic [1:0]   elvl;
        logic [127:0] erow;
    } vec_t;

    vec_t tbl[5];

    saxpy_row_serializer dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .vec_in    (vec_in),
        .vec_valid (vec_valid),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_last  (row_last),
        .row_idx   (row_idx),
        .level     (level),
        .overflow  (overflow)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    function automatic logic [511:0] mk(input logic [31:0] base);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = base + 32'(i);
        return v;
    endfunction

    function automatic logic [511:0] rnd_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic vv, input logic [511:0] vd, input logic rdy);
        if (r) begin
            mq.delete();
            m_idx = 0;
            m_ovf = 0;
            return;
        end
        if (mq.size() != 0 && rdy) begin
            if (m_idx == 3) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (vv) begin
            if (mq.size() < 2) mq.push_back(vd);
            else m_ovf = 1;
        end
    endtask

    task automatic check_model();
        logic [511:0] head;
        logic         ev;
        ev = (mq.size() != 0);
        chk("row_valid", 128'(row_valid), 128'(ev));
        chk("level", 128'(level), 128'(mq.size()));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("row_idx", 128'(row_idx), 128'(m_idx));
        chk("row_last", 128'(row_last), 128'(ev && m_idx == 3));
        if (ev) begin
            head = mq[0];
            chk("row_out", row_out, head[m_idx*128 +: 128]);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic cycle(input logic vv, input logic [511:0] vd, input logic rdy);
        vec_valid = vv;
        vec_in    = vd;
        row_ready = rdy;
        if (!rst && row_valid && rdy) beats++;
        @(posedge ref_clk);
        model_update(rst, vv, vd, rdy);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, mk(32'hDEAD0000), 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 128'h00000004_00000003_00000002_00000001};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 128'h00000008_00000007_00000006_00000005};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd1, 128'h0000000C_0000000B_0000000A_00000009};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 128'h00000010_0000000F_0000000E_0000000D};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 128'h0};

        rst       = 1'b1;
        vec_valid = 1'b0;
        vec_in    = '0;
        row_ready = 1'b0;
        cycle(1'b0, '0, 1'b0);
        do_reset();
        chk("reset_row_out", row_out, 128'h0);

        // Single vector, continuous ready: directed table.
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].vv, tbl[i].vv ? mk(32'd1) : 512'h0, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 128'(row_valid), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d_idx", i), 128'(row_idx), 128'(tbl[i].eidx));
            chk($sformatf("tbl%0d_last", i), 128'(row_last), 128'(tbl[i].elast));
            chk($sformatf("tbl%0d_level", i), 128'(level), 128'(tbl[i].elvl));
            if (tbl[i].ev) chk($sformatf("tbl%0d_row", i), row_out, tbl[i].erow);
        end

        // Ready toggling 1,0,0,1,0,1,1 after the strobe.
        cycle(1'b1, mk(32'd1), 1'b0);
        beats = 0;
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            for (int i = 0; i < 7; i++) cycle(1'b0, '0, pat[i]);
        end
        chk("toggle_beats", 128'(beats), 128'd4);
        chk("toggle_level", 128'(level), 128'd0);

        // Two vectors four cycles apart, back-to-back output.
        cycle(1'b1, mk(32'h100), 1'b1);
        beats = 0;
        for (int i = 1; i < 4; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk(32'h200), 1'b1);
        for (int i = 5; i < 9; i++) cycle(1'b0, '0, 1'b1);
        chk("two_vec_beats", 128'(beats), 128'd8);
        chk("two_vec_ovf", 128'(overflow), 128'd0);
        cycle(1'b0, '0, 1'b1);

        // Overflow with stalled sink, then drain.
        cycle(1'b1, mk(32'h300), 1'b0);
        cycle(1'b1, mk(32'h400), 1'b0);
        chk("ovf_level2", 128'(level), 128'd2);
        cycle(1'b1, mk(32'h500), 1'b0);
        chk("ovf_set", 128'(overflow), 128'd1);
        beats = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        chk("ovf_drain_beats", 128'(beats), 128'd8);
        chk("ovf_sticky", 128'(overflow), 128'd1);
        do_reset();

        // Full buffer with strobe coinciding with the last-row beat.
        cycle(1'b1, mk(32'h600), 1'b0);
        cycle(1'b1, mk(32'h680), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        chk("full_pop_idx3", 128'(row_last), 128'd1);
        cycle(1'b1, mk(32'h6C0), 1'b1);
        chk("full_pop_level", 128'(level), 128'd2);
        chk("full_pop_ovf", 128'(overflow), 128'd0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1);

        // Mid-stream reset after two beats with another vector queued.
        cycle(1'b1, mk(32'h700), 1'b1);
        cycle(1'b1, mk(32'h780), 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("mid_idx2", 128'(row_idx), 128'd2);
        do_reset();
        chk("mid_rst_valid", 128'(row_valid), 128'd0);
        chk("mid_rst_level", 128'(level), 128'd0);
        chk("mid_rst_idx", 128'(row_idx), 128'd0);
        cycle(1'b1, mk(32'h800), 1'b1);
        chk("mid_fresh_row0", row_out, 128'h00000803_00000802_00000801_00000800);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, rnd_vec(), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/saxpy_row_serializer.md
Name: saxpy_row_serializer

Overview:
Downstream stage of the saxpy unit. Captures each 512-bit saxpy result vector (16 x 32-bit words, 4x4 matrix) on its one-cycle valid pulse and buffers it in a small FIFO. Streams the buffered vectors out as four 128-bit rows over a valid/ready handshake. Upstream cannot be stalled, so any drop is flagged with a sticky overflow bit.

Parameters:
WORD_W, 32, bits per matrix element
LANES, 4, elements per row beat (row width = WORD_W*LANES = 128)
ROWS, 4, row beats per vector (vector width = 512)
DEPTH, 2, vector entries in the buffer (power of 2, >=2)

Ports:
ref_clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
vec_in  input  WORD_W*LANES*ROWS  result vector; word i at bits [32*(i+1)-1 -: 32]
vec_valid  input  1  single-cycle strobe; vec_in is valid this cycle
row_out  output  WORD_W*LANES  current row; row r = vec bits [128*(r+1)-1 -: 128]
row_valid  output  1  row_out valid
row_ready  input  1  downstream accepts the row
row_last  output  1  high with row_valid on row ROWS-1
row_idx  output  2  index of the row on row_out
level  output  2  vectors held, 0..DEPTH
overflow  output  1  sticky; a vector was dropped

Behaviour:
- Reset (rst=1 at edge): wptr=rptr=0, level=0, row_idx=0, overflow=0, row_valid=0, row_last=0, row_out=0. vec_valid is ignored in a reset cycle. Reset mid-stream discards all buffered data and any partially sent vector.
- Beat handshake: beat = row_valid && row_ready at the edge. Pop = beat && row_idx==ROWS-1.
- Push: on vec_valid, write vec_in at wptr when level<DEPTH, or when level==DEPTH and pop occurs in the same cycle. wptr advances and wraps modulo DEPTH.
- Drop: vec_valid with level==DEPTH and no same-cycle pop leaves the buffer unchanged and sets overflow=1. overflow stays set until rst.
- level: +1 on push only, -1 on pop only, unchanged on push+pop. Updated at the edge.
- row_valid = (level!=0). It is derived from registered state, so a vector pushed at edge N presents row 0 starting in cycle N+1. A push into an empty buffer with no pop has 1-cycle latency.
- row_out = entry[rptr] slice row_idx, driven from registered storage. row_out, row_idx and row_last hold stable while row_valid && !row_ready.
- On a beat: if row_idx<ROWS-1, row_idx increments. Otherwise row_idx returns to 0, rptr advances modulo DEPTH, and level decrements.
- Output order: rows go out 0,1,2,3 within a vector, and vectors in arrival order. No reordering, no gaps beyond ready stalls.
- row_ready while row_valid=0 has no effect.
- Continuous row_ready: one vector per 4 cycles. The saxpy producer cannot exceed one vector per 4 cycles (4 input beats per result), so a continuous-ready sink never overflows.
- Arithmetic: pass-through only. Data is never modified, saturated or byte-swapped.
- When row_valid=0, row_out holds its last value (don't-care to the sink).

Test Plan:
- Single vector, word i = i+1, row_ready=1 throughout. Expected: row_valid rises the cycle after the strobe. Four beats: row0=0x00000004_00000003_00000002_00000001 ... row3=0x00000010_0000000F_0000000E_0000000D. row_last only on beat 4. level goes 1 then 0.
- Same vector, row_ready toggling 1,0,0,1,0,1,1. Expected: row_out and row_idx unchanged across ready-low cycles, exactly 4 beats in order, no duplicated or skipped row.
- Two vectors strobed 4 cycles apart (words 0x100+i, then 0x200+i), row_ready=1. Expected: 8 consecutive beats, the second vector's row0 immediately after the first vector's row3, overflow=0.
- row_ready=0, three strobes. Expected: level=2 after two, overflow=1 after the third. Then ready=1 drains exactly the first two vectors (8 beats). overflow stays 1.
- Buffer full (level=2), row_ready=1, strobe in the same cycle as the row_last beat. Expected: vector accepted, level stays 2, overflow=0, new vector emitted after the remaining buffered one.
- Mid-stream reset after 2 beats of a vector, with another queued. Expected: next cycle row_valid=0, level=0, row_idx=0, overflow=0. A fresh strobe afterwards starts at row0.
